ucie_sb_tx_packetizer: RTL and testbench

UCIE_SB_TX_PACKETIZER -- requirements
Module: ucie_sb_tx_packetizer

---
 rtl/ucie_sb_tx_packetizer.sv | 179 +++++++++++++++++
 tb/tb_ucie_sb_tx_packetizer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_sb_tx_packetizer.sv
// ---------------------------------------------------------------------------
// ucie_sb_tx_packetizer
//   Buffers 64-bit sideband messages in a small FIFO and serialises each one
//   onto an 8-bit valid/ready byte stream toward the PHY, byte 0 first.
//   GAP_CYCLES idle cycles follow every message. A message whose current
//   byte is stalled for TIMEOUT_CYCLES consecutive cycles is dropped.
//
//   Optional feature: define UCIE_SB_PARITY_EN to append a ninth byte
//   holding the XOR of message bytes 0-7.
//
// Ports
//   clk          block clock, rising edge
//   resetn       async active-low reset
//   msg_valid    upstream message strobe
//   msg_ready    FIFO can accept a message (registered !full, no bypass)
//   msg_data     64-bit message, byte 0 = [7:0]
//   sb_data_tx   byte toward the PHY (0 when not sending)
//   sb_valid_tx  sb_data_tx valid
//   sb_ready_tx  PHY accepts the byte this cycle
//   msg_sent     1-cycle pulse after the last byte handshake
//   tx_timeout   1-cycle pulse after a message is aborted
//   busy         FSM not IDLE or FIFO non-empty
//   fifo_level   occupied FIFO entries
// ---------------------------------------------------------------------------
module ucie_sb_tx_packetizer #(
  parameter int FIFO_DEPTH     = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [63:0]                   msg_data,
  output logic [7:0]                    sb_data_tx,
  output logic                          sb_valid_tx,
  input  logic                          sb_ready_tx,
  output logic                          msg_sent,
  output logic                          tx_timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UCIE_SB_PARITY_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif
  localparam logic [3:0]    LAST_IDX = 4'(NBYTES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] TMO_LAST = SW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                       state_q, state_d;
  logic [FIFO_DEPTH-1:0][63:0]  mem_q;
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [AW:0]                  count_q, count_d;
  logic                         init_q;
  logic [3:0]                   idx_q, idx_d;
  logic [SW-1:0]                stall_q, stall_d;
  logic [GW-1:0]                gap_q, gap_d;
  logic                         sent_q, tmo_q;

  logic        full, empty, push, hs, last_hs, stall, abort, pop, gap_done;
  logic [63:0] head;
  logic [7:0]  cur_byte;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // init_q keeps msg_ready low while in reset and rises on the first edge after.
  assign push  = msg_valid && init_q && !full;
  assign hs    = (state_q == SEND) && sb_ready_tx;
  assign last_hs = hs && (idx_q == LAST_IDX);
  assign stall = (state_q == SEND) && !sb_ready_tx;
  // abort on the edge that ends the TIMEOUT_CYCLES-th consecutive stall
  assign abort = stall && (stall_q == TMO_LAST);
  assign pop   = last_hs || abort;
  assign gap_done = (state_q == GAP) && ((32'(gap_q) + 32'd1) >= 32'(GAP_CYCLES));

  assign head = mem_q[rd_ptr_q];

`ifdef UCIE_SB_PARITY_EN
  logic [7:0] parity;
  always_comb begin
    parity = '0;
    for (int b = 0; b < 8; b++) parity = parity ^ head[b*8 +: 8];
  end
  assign cur_byte = idx_q[3] ? parity : head[{idx_q[2:0], 3'b000} +: 8];
`else
  assign cur_byte = head[{idx_q[2:0], 3'b000} +: 8];
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = SEND;
      SEND:    if (pop)    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sb_valid_tx = 1'b0;
    sb_data_tx  = '0;
    if (state_q == SEND) begin
      sb_valid_tx = 1'b1;
      sb_data_tx  = cur_byte;
    end
    busy       = (state_q != IDLE) || !empty;
    msg_ready  = init_q && !full;
    msg_sent   = sent_q;
    tx_timeout = tmo_q;
    fifo_level = count_q;
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    idx_d = idx_q;
    if (pop || state_q != SEND) idx_d = '0;
    else if (hs)                idx_d = idx_q + 4'd1;

    stall_d = stall_q;
    if (state_q != SEND || hs || abort) stall_d = '0;
    else if (stall_q != '1)             stall_d = stall_q + 1'b1;

    gap_d = '0;
    if (state_q == GAP && !gap_done) gap_d = gap_q + 1'b1;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
      idx_q    <= '0;
      stall_q  <= '0;
      gap_q    <= '0;
      sent_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      idx_q    <= idx_d;
      stall_q  <= stall_d;
      gap_q    <= gap_d;
      sent_q   <= last_hs;
      tmo_q    <= abort;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= msg_data;
  end

endmodule

// File: tb/tb_ucie_sb_tx_packetizer.sv
// Scoreboard bench: stimulus pushes expected bytes/events into queues, a
// negedge monitor pops and compares on every byte handshake and pulse.
module tb_ucie_sb_tx_packetizer;
`ifdef UCIE_SB_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        msg_valid;
  logic        msg_ready;
  logic [63:0] msg_data;
  logic [7:0]  sb_data_tx;
  logic        sb_valid_tx;
  logic        sb_ready_tx;
  logic        msg_sent;
  logic        tx_timeout;
  logic        busy;
  logic [1:0]  fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [1:0] evt_q[$];   // 2'b01 = msg_sent, 2'b10 = tx_timeout
  logic [7:0] e_byte;
  logic [1:0] e_evt;

  ucie_sb_tx_packetizer dut (
    .clk(clk), .resetn(resetn), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .sb_data_tx(sb_data_tx), .sb_valid_tx(sb_valid_tx),
    .sb_ready_tx(sb_ready_tx), .msg_sent(msg_sent), .tx_timeout(tx_timeout),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bget(input logic [63:0] d, input int i);
    logic [7:0] p;
    if (i < 8) return d[i*8 +: 8];
    p = 8'h00;
    for (int k = 0; k < 8; k++) p = p ^ d[k*8 +: 8];
    return p;
  endfunction

  task automatic push_msg(input logic [63:0] d, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(bget(d, i));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 400) begin tick; n++; end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s: busy=1 after %0d cycles, expected 0", nm, n);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (sb_valid_tx && sb_ready_tx) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_byte: got %02h expected none", sb_data_tx);
        end else begin
          e_byte = exp_q.pop_front();
          if (sb_data_tx !== e_byte) begin
            n_bad++;
            $display("FAIL sb_byte: got %02h expected %02h", sb_data_tx, e_byte);
          end
        end
      end
      if (msg_sent || tx_timeout) begin
        n_cmp++;
        if (evt_q.size() == 0) begin
          n_bad++;
          $display("FAIL evt: got sent=%0b timeout=%0b expected none", msg_sent, tx_timeout);
        end else begin
          e_evt = evt_q.pop_front();
          if ({tx_timeout, msg_sent} !== e_evt) begin
            n_bad++;
            $display("FAIL evt: got %02b expected %02b", {tx_timeout, msg_sent}, e_evt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] M1 = 64'h0807060504030201;
  localparam logic [63:0] MA = 64'h1122334455667788;
  localparam logic [63:0] MB = 64'h99AABBCCDDEEFF00;
  localparam logic [63:0] MC = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] MD = 64'hA7A6A5A4A3A2A1A0;
  localparam logic [63:0] ME = 64'hC7C6C5C4C3C2C1C0;
  localparam logic [63:0] MF = 64'hF7F6F5F4F3F2F1F0;
  localparam logic [63:0] MG = 64'hE7E6E5E4E3E2E1E0;

  initial begin
    resetn = 1'b0; msg_valid = 1'b0; msg_data = '0; sb_ready_tx = 1'b0;
    // ---- reset state ----
    tick; tick;
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_sb_valid", sb_valid_tx, 0);
    chk("rst_sb_data", sb_data_tx, 0);
    chk("rst_msg_sent", msg_sent, 0);
    chk("rst_timeout", tx_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    resetn = 1'b1;
    tick;
    chk("post_rst_ready", msg_ready, 1);

    // ---- single message, PHY always ready ----
    sb_ready_tx = 1'b1;
    msg_valid = 1'b1; msg_data = M1; push_msg(M1, NB); evt_q.push_back(2'b01);
    tick;                                   // accepted in cycle N
    msg_valid = 1'b0;
    chk("t1_n1_valid", sb_valid_tx, 0);
    chk("t1_n1_level", fifo_level, 1);
    tick;                                   // cycle N+2
    chk("t1_first_valid", sb_valid_tx, 1);
    chk("t1_first_byte", sb_data_tx, 8'h01);
    repeat (NB - 1) tick;
    chk("t1_last_byte", sb_data_tx, 8'h08);
    tick;
    chk("t1_sent", msg_sent, 1);
    chk("t1_gap0_valid", sb_valid_tx, 0);
    chk("t1_level0", fifo_level, 0);
    tick;
    chk("t1_sent_pulse", msg_sent, 0);
    chk("t1_gap1_valid", sb_valid_tx, 0);
    chk("t1_gap1_busy", busy, 1);
    tick;
    chk("t1_idle_busy", busy, 0);

    // ---- back-to-back pushes with PHY stalled ----
    sb_ready_tx = 1'b0;
    msg_valid = 1'b1; msg_data = MA; push_msg(MA, NB); evt_q.push_back(2'b01);
    tick;
    chk("t2_ready_after1", msg_ready, 1);
    msg_data = MB; push_msg(MB, NB); evt_q.push_back(2'b01);
    tick;
    msg_data = MC;
    chk("t2_ready_full", msg_ready, 0);
    chk("t2_level_full", fifo_level, 2);
    chk("t2_hold_valid", sb_valid_tx, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_byte", sb_data_tx, 8'h88);
      tick;
    end
    chk("t2_level_still", fifo_level, 2);
    sb_ready_tx = 1'b1;
    for (int i = 0; i < NB; i++) begin
      chk("t2_no_bypass", msg_ready, 0);
      tick;
    end
    chk("t2_ready_after_pop", msg_ready, 1);
    push_msg(MC, NB); evt_q.push_back(2'b01);
    tick;
    msg_valid = 1'b0;
    wait_idle("t2_drain");

    // ---- stall timeout during byte 3 ----
    sb_ready_tx = 1'b1;
    msg_valid = 1'b1; msg_data = MD; push_msg(MD, 3); evt_q.push_back(2'b10);
    tick;
    msg_data = ME; push_msg(ME, NB); evt_q.push_back(2'b01);
    tick;
    msg_valid = 1'b0;
    tick; tick; tick;                       // byte 3 on the bus
    sb_ready_tx = 1'b0;
    chk("t3_stall_byte", sb_data_tx, 8'hA3);
    repeat (254) tick;
    chk("t3_pre_timeout", tx_timeout, 0);
    chk("t3_pre_valid", sb_valid_tx, 1);
    chk("t3_pre_level", fifo_level, 2);
    tick;
    chk("t3_timeout", tx_timeout, 1);
    chk("t3_no_sent", msg_sent, 0);
    chk("t3_level_dec", fifo_level, 1);
    chk("t3_gap0_valid", sb_valid_tx, 0);
    sb_ready_tx = 1'b1;
    tick;
    chk("t3_timeout_pulse", tx_timeout, 0);
    chk("t3_gap1_valid", sb_valid_tx, 0);
    tick;
    chk("t3_idle_valid", sb_valid_tx, 0);
    tick;
    chk("t3_next_valid", sb_valid_tx, 1);
    chk("t3_next_byte", sb_data_tx, 8'hC0);
    wait_idle("t3_drain");

    // ---- reset mid-message with FIFO full ----
    sb_ready_tx = 1'b1;
    msg_valid = 1'b1; msg_data = MF; push_msg(MF, 4);
    tick;
    msg_data = MG;
    tick;
    msg_valid = 1'b0;
    tick; tick; tick; tick;                 // byte 4 on the bus
    chk("t4_byte4", sb_data_tx, 8'hF4);
    chk("t4_full", fifo_level, 2);
    resetn = 1'b0;
    #1;
    chk("t4_rst_valid", sb_valid_tx, 0);
    chk("t4_rst_data", sb_data_tx, 0);
    chk("t4_rst_ready", msg_ready, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_level", fifo_level, 0);
    tick; tick;
    resetn = 1'b1;
    tick;
    chk("t4_ready_after", msg_ready, 1);
    repeat (6) tick;
    chk("t4_quiet_valid", sb_valid_tx, 0);
    chk("t4_quiet_busy", busy, 0);

    chk("sb_queue_drained", exp_q.size(), 0);
    chk("evt_queue_drained", evt_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
